// File: rtl/pfx_pkg.sv
// Shared definitions for the prefix-sum output path: default sizes,
// index-width helper and drain FSM state encoding.
package pfx_pkg;

   localparam int IWIDTH_DEF = 8;
   localparam int V_LEN_DEF  = 16;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int IDX_W = idx_w(V_LEN_DEF);

   typedef logic [0:0] state_t;
   localparam state_t IDLE  = 1'b0;
   localparam state_t DRAIN = 1'b1;

endpackage

// File: rtl/pfx_vbuf.sv
// Two-slot ping-pong vector store with occupancy count and an element read port
// that can look at either the current read slot or the one behind it.
module pfx_vbuf import pfx_pkg::*; #(
   parameter int IWIDTH = IWIDTH_DEF,
   parameter int V_LEN  = V_LEN_DEF,
   localparam int XW    = idx_w(V_LEN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  logic [V_LEN*IWIDTH-1:0]  wdata,
   input  logic                     free,
   input  logic                     rd_other,
   input  logic [XW-1:0]            ridx,
   output logic [IWIDTH-1:0]        rdata,
   output logic                     full,
   output logic                     empty
);

   logic [V_LEN-1:0][IWIDTH-1:0] slot [2];
   logic                         wr_ptr;
   logic                         rd_ptr;
   logic [1:0]                   count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr)
            wr_ptr <= ~wr_ptr;
         if (free)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, wr} - {1'b0, free};
      end
   end

   // Slot contents need no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (wr)
         slot[wr_ptr] <= wdata;
   end

   assign rdata = slot[rd_ptr ^ rd_other][ridx];
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/pfx_drain.sv
// Buffers prefix-sum result vectors and streams them out one element per
// cycle over valid/ready, flagging vectors dropped while both slots are busy.
module pfx_drain import pfx_pkg::*; #(
   parameter int IWIDTH = IWIDTH_DEF,
   parameter int V_LEN  = V_LEN_DEF,
   localparam int XW    = idx_w(V_LEN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [V_LEN*IWIDTH-1:0]  ivec,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [IWIDTH-1:0]        out_data,
   output logic [XW-1:0]            out_idx,
   output logic                     out_last,
   output logic                     busy,
   output logic                     overflow
);

   localparam logic [XW-1:0] LAST_IDX = XW'(V_LEN - 1);

   state_t            state;
   logic              hs, fin, accept, full, empty, rd_other;
   logic [XW-1:0]     ridx;
   logic [IWIDTH-1:0] rdata;

   assign out_valid = (state == DRAIN);
   assign hs        = out_valid & out_ready;
   assign fin       = hs & out_last;
   // A slot freed by the final handshake can take a new vector the same cycle.
   assign accept    = valid_in & (~full | fin);
   assign busy      = ~empty;

   // Next element to present: idx+1 mid-vector, else element 0 of the next slot.
   always_comb begin
      rd_other = fin;
      ridx     = (hs & ~out_last) ? out_idx + 1'b1 : '0;
   end

   pfx_vbuf #(.IWIDTH(IWIDTH), .V_LEN(V_LEN)) u_vbuf (
      .clk      (clk),
      .rst      (rst),
      .wr       (accept),
      .wdata    (ivec),
      .free     (fin),
      .rd_other (rd_other),
      .ridx     (ridx),
      .rdata    (rdata),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         out_data <= '0;
         out_idx  <= '0;
         out_last <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (valid_in & ~accept)
            overflow <= 1'b1;
         if (state == IDLE) begin
            if (~empty) begin
               state    <= DRAIN;
               out_data <= rdata;
               out_idx  <= ridx;
               out_last <= (ridx == LAST_IDX);
            end
         end else if (hs) begin
            // Stay in DRAIN mid-vector, or at the end when the other slot holds a vector.
            if (~out_last | full) begin
               out_data <= rdata;
               out_idx  <= ridx;
               out_last <= (ridx == LAST_IDX);
            end else begin
               state    <= IDLE;
               out_data <= '0;
               out_idx  <= '0;
               out_last <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pfx_drain.sv
// Bench for pfx_drain: directed tables and corner sequences plus randomized
// traffic, all beats checked by a queue-of-vectors reference model.
module tb_pfx_drain;
   import pfx_pkg::*;

   localparam int IW = 8;
   localparam int VL = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid_in = 1'b0;
   logic [VL*IW-1:0]  ivec = '0;
   logic              out_ready = 1'b0;
   logic              out_valid;
   logic [IW-1:0]     out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic              busy;
   logic              overflow;

   always #5 clk = ~clk;

   pfx_drain #(.IWIDTH(IW), .V_LEN(VL)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .ivec      (ivec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .overflow  (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: queue of buffered vectors, beat position in the head vector.
   logic [VL*IW-1:0] mq[$];
   logic [VL*IW-1:0] mv;
   int               m_beat;
   bit               m_ovf;
   bit               m_fin;
   bit               p_stall;
   logic [IW-1:0]    p_data;
   logic [IDX_W-1:0] p_idx;
   logic             p_last;

   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         m_beat  = 0;
         m_ovf   = 0;
         p_stall = 0;
      end else begin
         chk("mon_busy", busy, mq.size() != 0);
         chk("mon_overflow", overflow, m_ovf);
         if (p_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, p_data);
            chk("hold_idx", out_idx, p_idx);
            chk("hold_last", out_last, p_last);
         end
         m_fin = 0;
         if (out_valid && out_ready) begin
            if (mq.size() == 0) begin
               chk("beat_unexpected", 1, 0);
            end else begin
               mv = mq[0];
               chk("beat_data", out_data, mv[m_beat*IW +: IW]);
               chk("beat_idx", out_idx, m_beat);
               chk("beat_last", out_last, m_beat == VL - 1);
               if (m_beat == VL - 1) begin
                  m_fin  = 1;
                  m_beat = 0;
                  void'(mq.pop_front());
               end else begin
                  m_beat++;
               end
            end
         end
         if (valid_in) begin
            if (mq.size() < 2) mq.push_back(ivec);
            else m_ovf = 1;
         end
         p_stall = out_valid && !out_ready;
         p_data  = out_data;
         p_idx   = out_idx;
         p_last  = out_last;
      end
   end

   typedef struct {
      logic             rdy;
      logic             vld;
      logic [IW-1:0]    data;
      logic [IDX_W-1:0] idx;
      logic             last;
      logic             bsy;
   } row_t;

   row_t tbl[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [VL*IW-1:0] v);
      valid_in = 1'b1;
      ivec     = v;
      step();
      valid_in = 1'b0;
   endtask

   function automatic logic [VL*IW-1:0] splat(input logic [IW-1:0] b);
      return {VL{b}};
   endfunction

   function automatic logic [VL*IW-1:0] ramp3();
      logic [VL*IW-1:0] v;
      for (int k = 0; k < VL; k++) v[k*IW +: IW] = IW'(3 * k);
      return v;
   endfunction

   // Per-cycle expectations for one 3k vector under an always/stalling ready pattern.
   task automatic build_tbl(input bit stall);
      row_t r;
      int   k = 0;
      int   c = 1;
      tbl.delete();
      r = '{rdy: 1'b1, vld: 1'b0, data: '0, idx: '0, last: 1'b0, bsy: 1'b1};
      tbl.push_back(r);
      while (k < VL) begin
         r.rdy  = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         r.vld  = 1'b1;
         r.data = IW'(3 * k);
         r.idx  = IDX_W'(k);
         r.last = (k == VL - 1);
         r.bsy  = 1'b1;
         tbl.push_back(r);
         if (r.rdy) k++;
         c++;
      end
      r = '{rdy: 1'b1, vld: 1'b0, data: '0, idx: '0, last: 1'b0, bsy: 1'b0};
      tbl.push_back(r);
   endtask

   task automatic run_tbl(input string nm);
      for (int i = 0; i < tbl.size(); i++) begin
         chk({nm, "_valid"}, out_valid, tbl[i].vld);
         chk({nm, "_busy"}, busy, tbl[i].bsy);
         if (tbl[i].vld) begin
            chk({nm, "_data"}, out_data, tbl[i].data);
            chk({nm, "_idx"}, out_idx, tbl[i].idx);
            chk({nm, "_last"}, out_last, tbl[i].last);
         end
         out_ready = tbl[i].rdy;
         step();
      end
   endtask

   task automatic wait_idx(input int idx, input string nm);
      int n = 0;
      while (!(out_valid && out_idx == idx) && n < 300) begin
         step();
         n++;
      end
      chk(nm, n < 300, 1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 300) begin
         step();
         n++;
      end
      chk(nm, n < 300, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      step();
      rst = 1'b0;
   endtask

   int cnt, first, last;
   bit prev_v;

   initial begin
      step();
      do_reset();
      step();

      // Single vector, ready high, then with 1,0,0,1 backpressure.
      build_tbl(1'b0);
      send(ramp3());
      run_tbl("single");
      build_tbl(1'b1);
      send(ramp3());
      run_tbl("stall");

      // Two vectors two cycles apart drain as 32 contiguous beats.
      out_ready = 1'b1;
      cnt = 0; first = -1; last = -1;
      ivec = splat(8'h11);
      valid_in = 1'b1;
      for (int i = 0; i < 45; i++) begin
         if (out_valid) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
         step();
         valid_in = (i == 1);
         if (i == 1) ivec = splat(8'h22);
      end
      chk("b2b_beats", cnt, 32);
      chk("b2b_span", last - first + 1, 32);
      chk("b2b_overflow", overflow, 0);

      // Third vector while both slots are full is dropped.
      out_ready = 1'b0;
      send(splat(8'hA1));
      step();
      send(splat(8'hB2));
      step();
      chk("ovf_before", overflow, 0);
      send(splat(8'hC3));
      chk("ovf_after", overflow, 1);
      out_ready = 1'b1;
      wait_idle("ovf_drain_timeout");
      chk("ovf_sticky", overflow, 1);
      do_reset();
      step();

      // Capture on the final-element handshake with both slots full.
      out_ready = 1'b0;
      send(splat(8'h5A));
      step();
      send(splat(8'h6B));
      out_ready = 1'b1;
      wait_idx(15, "simul_wait");
      valid_in = 1'b1;
      ivec = splat(8'h7C);
      step();
      valid_in = 1'b0;
      chk("simul_overflow", overflow, 0);
      chk("simul_busy", busy, 1);
      wait_idle("simul_drain_timeout");
      chk("simul_overflow_end", overflow, 0);

      // Reset in the middle of a drain with a second vector buffered.
      out_ready = 1'b0;
      send(ramp3());
      send(splat(8'h44));
      out_ready = 1'b1;
      wait_idx(7, "mid_wait");
      do_reset();
      send(splat(8'hD0));
      wait_idx(0, "after_rst_wait");
      chk("after_rst_data", out_data, 8'hD0);
      wait_idle("after_rst_timeout");

      // Randomized traffic, including occasional overflow.
      do_reset();
      prev_v = 0;
      for (int i = 0; i < 3000; i++) begin
         valid_in  = !prev_v && ($urandom_range(0, 9) == 0);
         prev_v    = valid_in;
         ivec      = {$urandom, $urandom, $urandom, $urandom};
         out_ready = ($urandom_range(0, 9) < 7);
         step();
      end
      valid_in  = 1'b0;
      out_ready = 1'b1;
      wait_idle("rand_drain_timeout");
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pfx_drain.md
# pfx_drain

Output stage directly downstream of the prefix-sum block. Captures each completed V_LEN-element result vector on its single-cycle valid pulse and drains it one element per cycle over a valid/ready stream, with element index and last marker. The prefix-sum block has no backpressure, so this stage provides two vector slots and flags any vector it is forced to drop.

## Interface
Parameters:
- IWIDTH, 8, element width in bits
- V_LEN, 16, elements per vector (≥2)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  single-cycle pulse, ivec valid (from prefix-sum valid_out)
- ivec  in  V_LEN*IWIDTH  flat vector; element k = ivec[(k+1)*IWIDTH-1 : k*IWIDTH]
- out_valid  out  1  out_data/out_idx/out_last valid
- out_ready  in  1  consumer accepts when high with out_valid
- out_data  out  IWIDTH  current element
- out_idx  out  $clog2(V_LEN)  index of current element within vector
- out_last  out  1  high with element V_LEN-1
- busy  out  1  at least one slot occupied
- overflow  out  1  sticky: a vector was dropped

## Operation
- Two vector slots, written ping-pong (wr_ptr), read ping-pong (rd_ptr); occupancy count 0..2.
- Capture: valid_in with count<2 → ivec written to slot wr_ptr, wr_ptr toggles, count+1.
- Drain FSM, states IDLE and DRAIN:
  - IDLE: out_valid=0. Next cycle count>0 (or capture this cycle) → DRAIN, idx=0.
  - DRAIN: out_data = slot[rd_ptr] element idx. On handshake (out_valid&out_ready): idx<V_LEN-1 → idx+1; idx=V_LEN-1 → slot freed, rd_ptr toggles, count-1, idx=0; stay DRAIN if another slot is still full, else IDLE.
- Elements emitted strictly in order 0..V_LEN-1; vectors in arrival order.
- Held outputs: while out_valid & !out_ready, out_data/out_idx/out_last stay stable.
- Simultaneous capture and final-element handshake with count=2: the freed slot is reused; vector accepted, count stays 2, no overflow.
- Overflow: valid_in with count=2 and no final-element handshake that cycle → vector discarded, overflow set, stays set until rst. Buffered data unaffected.
- busy = (count≠0).
- Width rules: data passes through unmodified; idx wraps from V_LEN-1 to 0 only on vector completion.

## Timing
- Reset (async assert, sync-safe deassert): out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overflow=0, count=0, both pointers 0, FSM IDLE. Reset mid-drain discards all buffered vectors immediately.
- Latency: valid_in at edge N → element 0 on out_valid after edge N+1 (one registered cycle) when FSM was IDLE.
- Throughput: one element per cycle with out_ready held high; back-to-back vectors drain with no bubble between element V_LEN-1 of one and element 0 of the next.
- Full vector drain, ready always high: V_LEN cycles.
- out_valid never drops without a handshake once asserted.

## Structure
- Shared package pfx_pkg: FSM state typedef (IDLE, DRAIN), helper localparam IDX_W = $clog2(V_LEN); shared with the prefix-sum block for IWIDTH/V_LEN defaults.
- One sub-module: pfx_vbuf — 2-slot vector store with wr/rd pointers, count, full/empty, element-select read port. pfx_drain holds FSM, index counter, output regs, overflow flag.

## Test plan
- Single vector, V_LEN=16, IWIDTH=8, ivec elements k=0..15 value 3k, out_ready=1 → 16 beats, data 0,3,…,45, idx 0..15, out_last only on idx 15, first beat one cycle after valid_in, busy low after last.
- Backpressure: same vector, out_ready toggles 1,0,0,1,… → no element lost or duplicated, outputs stable during stall cycles, order preserved.
- Two vectors 2 cycles apart (A: all 0x11, B: all 0x22), ready=1 → 32 contiguous beats, A then B, no bubble, overflow=0.
- Overflow: ready=0, three valid_in pulses (A,B,C) → overflow=1 after third; then ready=1 → only A and B drained; overflow stays 1.
- Simultaneous: count=2, ready=1, valid_in pulse with C exactly on A's last-element handshake → C accepted, drained after B, overflow=0.
- Reset mid-drain: assert rst during idx 7 of A with B buffered → outputs all 0 immediately, busy=0; after release new vector D drains from idx 0.
